// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one quotient bit per clock, sign fix-up, one-cycle done pulse.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt, accept_state;
    logic             op_rem;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] dvsr, quo, rem, res_q;
    logic [CW-1:0]    cnt;

    logic             is_signed, a_neg, b_neg, accept, div_zero, calc_last;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   trial;

    assign is_signed = ~div_op[0];
    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign accept    = start & ~flush & ((state == IDLE) | (state == DONE));
    assign calc_last = (cnt == '0);
    // Remainder gains the next dividend bit from the top of the quotient shift register.
    assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    assign q_fix     = (sign_a ^ sign_b) ? -quo : quo;
    assign r_fix     = sign_a ? -rem : rem;

    always_comb begin
        accept_state = CALC;
        if (div_zero) begin
            accept_state = DONE;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (a_mag < b_mag) begin
            accept_state = FIX;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = accept_state;
            CALC: if (calc_last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = accept ? accept_state : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rem <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dvsr   <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            res_q  <= '0;
        end else if (accept) begin
            op_rem <= div_op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            dvsr   <= b_mag;
            cnt    <= CW'(WIDTH - 1);
            if (accept_state == FIX) begin
                quo <= '0;
                rem <= a_mag;
            end else begin
                quo <= a_mag;
                rem <= '0;
            end
            if (div_zero) begin
                res_q <= '0;
            end
        end else if (!flush) begin
            if (state == CALC) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                if (!calc_last) begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == FIX) begin
                res_q <= op_rem ? r_fix : q_fix;
            end
        end
    end

    assign busy   = (state == CALC) | (state == FIX);
    assign done   = (state == DONE);
    assign result = res_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled on rising clk.
REQ-005 The block SHALL have port div_op, input, 2 bits: 00 signed quotient, 01 unsigned quotient, 10 signed remainder, 11 unsigned remainder.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: operand A, sampled with an accepted start.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: operand B, sampled with an accepted start.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous abort of any operation in progress.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: quotient or remainder per the latched div_op.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX, and DONE.
REQ-013 The block SHALL accept start only in IDLE or DONE with flush low, and SHALL ignore start in CALC and FIX.
REQ-014 On acceptance, the block SHALL latch div_op, operand magnitudes, and both sign bits, then go to CALC; the iteration counter SHALL be set to WIDTH-1.
REQ-015 Each CALC cycle SHALL perform one restoring step (shift remainder/quotient left 1, trial subtract, keep if non-negative), yielding one quotient bit per cycle.
REQ-016 CALC SHALL go to FIX after exactly WIDTH cycles (counter reaches 0).
REQ-017 FIX SHALL apply sign correction for signed ops: the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign; FIX SHALL then go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 0.
REQ-019 DONE SHALL go to CALC if a start is accepted that cycle, else to IDLE.
REQ-020 Latency: start accepted at the end of cycle 0; busy=1 in cycles 1..WIDTH+1; done=1 in cycle WIDTH+2 (34 for WIDTH=32).
REQ-021 A divisor of 0 SHALL skip CALC and FIX and go directly from acceptance to DONE with result=0 for all div_op (done in cycle 1).
REQ-022 Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-023 result SHALL hold its last value from DONE until the next DONE; it SHALL not change in IDLE, CALC, or FIX.
REQ-024 flush=1 in any state SHALL move the FSM to IDLE next cycle with busy=0 and no done pulse; result SHALL be unchanged.
REQ-025 If flush and start are high together, flush SHALL win and start SHALL be dropped.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, and clear internal registers, regardless of clk.
REQ-027 rst asserted mid-operation SHALL discard the operation; no done SHALL follow the release of rst.

Configuration
REQ-028 Macro DIV_EARLY_OUT_EN, when defined, SHALL take an accepted start with unsigned |dividend| < |divisor| (divisor non-zero) straight to FIX, with quotient 0 and remainder |dividend|, so done is in cycle 2.
REQ-029 Without DIV_EARLY_OUT_EN, every non-zero-divisor operation SHALL take the full WIDTH+2 latency.

Verification
REQ-030 div_op=00, dividend=-7 (0xFFFFFFF9), divisor=2 -> done in cycle 34, result=0xFFFFFFFD (-3); with div_op=10 -> result=0xFFFFFFFF (-1).
REQ-031 div_op=01, dividend=0xFFFFFFFF, divisor=0x10 -> result=0x0FFFFFFF; div_op=11 -> result=0xF.
REQ-032 divisor=0, any div_op -> done in cycle 1, result=0; div_op=00 with 0x80000000 / 0xFFFFFFFF -> result=0x80000000.
REQ-033 A second start during CALC SHALL be ignored (single done, first result); start in the DONE cycle SHALL begin a new op with done 34 cycles later.
REQ-034 flush at cycle 10 of an op -> busy=0 in cycle 11, no done, result unchanged; rst at cycle 5 -> all outputs 0 immediately.
REQ-035 With DIV_EARLY_OUT_EN, div_op=11 with 3 / 5 -> done in cycle 2, result=3; without the macro -> done in cycle 34, result=3.
